mem_copy_initiator: RTL

//  Memory-bus initiator that copies a block of 16-bit words from a source to a destination address.

---
 rtl/mem_copy_initiator.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_copy_initiator.sv
// Memory-bus initiator that copies a block of words from a source to a destination address.
// Each word costs three bus cycles: read address, read data capture, write.
module mem_copy_initiator #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR,
      DONE
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [LEN_W-1:0]  remaining;
   logic [DATA_W-1:0] data_reg;

   // Pointers wrap naturally at the top of the address space.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         data_reg  <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (start) begin
                  src_ptr   <= src_addr;
                  dst_ptr   <= dst_addr;
                  remaining <= count;
               end
            end
            RD_DATA: data_reg <= read_data;
            WR: begin
               src_ptr   <= src_ptr + 1'b1;
               dst_ptr   <= dst_ptr + 1'b1;
               remaining <= remaining - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      mem_cmd    = MNONE;
      mem_addr   = '0;
      write_data = '0;
      case (state)
         IDLE: begin
            if (start) next_state = (count != '0) ? RD_ADDR : DONE;
         end
         RD_ADDR: begin
            busy       = 1'b1;
            mem_cmd    = MREAD;
            mem_addr   = src_ptr;
            next_state = RD_DATA;
         end
         RD_DATA: begin
            busy       = 1'b1;
            mem_cmd    = MREAD;
            mem_addr   = src_ptr;
            next_state = WR;
         end
         WR: begin
            busy       = 1'b1;
            mem_cmd    = MWRITE;
            mem_addr   = dst_ptr;
            write_data = data_reg;
            next_state = (remaining == LEN_W'(1)) ? DONE : RD_ADDR;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule
